// File: rtl/i2c_poll_sequencer.sv
// i2c_poll_sequencer
//   Drives a byte-level I2C master engine through a one-outstanding
//   command/response handshake. After enable it reads the device ID register
//   once and checks it against EXP_ID. It then reads the 16-bit temperature
//   register every POLL_CYCLES clocks and publishes each result.
//
// Ports
//   clk, reset              : system clock, async active-low reset
//   enable                  : run request
//   cmd_valid/cmd_ready     : command handshake towards the bit engine
//   cmd_op, cmd_data        : 0=START 1=WRITE 2=READ_ACK 3=READ_NACK 4=STOP, write byte
//   rsp_valid/data/nack     : one-cycle completion of the accepted command
//   id, id_valid            : last ID byte read, set once the ID matched
//   temp, temp_valid        : last temperature {MSB,LSB}, one-cycle update pulse
//   busy                    : START issue through STOP response of a transaction
//   error                   : sticky fault (ID mismatch or too many NACKs)
module i2c_poll_sequencer #(
    parameter logic [6:0]  DEV_ADDR    = 7'h4B,
    parameter logic [7:0]  ID_REG      = 8'hCB,
    parameter logic [7:0]  EXP_ID      = 8'hCB,
    parameter logic [7:0]  TEMP_REG    = 8'h00,
    parameter int unsigned POLL_CYCLES = 50000,
    parameter int unsigned RETRY_MAX   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [2:0]  cmd_op,
    output logic [7:0]  cmd_data,
    input  logic        rsp_valid,
    input  logic [7:0]  rsp_data,
    input  logic        rsp_nack,
    output logic [7:0]  id,
    output logic        id_valid,
    output logic [15:0] temp,
    output logic        temp_valid,
    output logic        busy,
    output logic        error
);

    localparam int unsigned TimerW = $clog2(POLL_CYCLES);

    localparam logic [2:0] OpStart    = 3'd0;
    localparam logic [2:0] OpWrite    = 3'd1;
    localparam logic [2:0] OpReadAck  = 3'd2;
    localparam logic [2:0] OpReadNack = 3'd3;
    localparam logic [2:0] OpStop     = 3'd4;

    typedef enum logic [3:0] {
        StIdle,
        StStart,
        StAddrW,
        StSub,
        StRstart,
        StAddrR,
        StRdHi,
        StRdLo,
        StStop,
        StWait,
        StFail
    } state_e;

    state_e              state_q, state_d;
    logic                pend_q, pend_d;         // 0: ISSUE phase, 1: PEND phase
    logic                txn_temp_q, txn_temp_d; // 1: temperature txn, 0: ID txn
    logic                nack_q, nack_d;         // current STOP is aborting a NACKed txn
    logic [1:0]          retry_q, retry_d;
    logic [TimerW-1:0]   timer_q, timer_d;
    logic [7:0]          msb_q, msb_d;
    logic [7:0]          lsb_q, lsb_d;
    logic [7:0]          id_q, id_d;
    logic                id_valid_q, id_valid_d;
    logic [15:0]         temp_q, temp_d;
    logic                temp_valid_q, temp_valid_d;
    logic                error_q, error_d;

    logic                cmd_xfer;
    logic                rsp_take;
    logic [2:0]          retry_inc;

    // Command presented by the current state; ISSUE phase only.
    always_comb begin
        cmd_valid = 1'b0;
        cmd_op    = OpStart;
        cmd_data  = 8'h00;
        busy      = 1'b0;
        unique case (state_q)
            StStart, StRstart: begin
                cmd_valid = !pend_q;
                cmd_op    = OpStart;
                busy      = 1'b1;
            end
            StAddrW: begin
                cmd_valid = !pend_q;
                cmd_op    = OpWrite;
                cmd_data  = {DEV_ADDR, 1'b0};
                busy      = 1'b1;
            end
            StSub: begin
                cmd_valid = !pend_q;
                cmd_op    = OpWrite;
                cmd_data  = txn_temp_q ? TEMP_REG : ID_REG;
                busy      = 1'b1;
            end
            StAddrR: begin
                cmd_valid = !pend_q;
                cmd_op    = OpWrite;
                cmd_data  = {DEV_ADDR, 1'b1};
                busy      = 1'b1;
            end
            StRdHi: begin
                cmd_valid = !pend_q;
                cmd_op    = OpReadAck;
                busy      = 1'b1;
            end
            StRdLo: begin
                cmd_valid = !pend_q;
                cmd_op    = OpReadNack;
                busy      = 1'b1;
            end
            StStop: begin
                cmd_valid = !pend_q;
                cmd_op    = OpStop;
                busy      = 1'b1;
            end
            default: ;
        endcase
    end

    assign cmd_xfer  = cmd_valid & cmd_ready;
    // Responses only count while a command is outstanding.
    assign rsp_take  = pend_q & rsp_valid;
    // Unsaturated increment so the count can be seen to exceed RETRY_MAX.
    assign retry_inc = {1'b0, retry_q} + 3'd1;

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        txn_temp_d   = txn_temp_q;
        nack_d       = nack_q;
        retry_d      = retry_q;
        timer_d      = timer_q;
        msb_d        = msb_q;
        lsb_d        = lsb_q;
        id_d         = id_q;
        id_valid_d   = id_valid_q;
        temp_d       = temp_q;
        temp_valid_d = 1'b0;
        error_d      = error_q;

        if (cmd_xfer) begin
            pend_d = 1'b1;
        end

        if (rsp_take) begin
            pend_d = 1'b0;
            unique case (state_q)
                StStart:  state_d = StAddrW;
                StRstart: state_d = StAddrR;
                StAddrW, StSub, StAddrR: begin
                    if (rsp_nack) begin
                        // Abandon the rest of the transaction, release the bus.
                        state_d = StStop;
                        nack_d  = 1'b1;
                    end else if (state_q == StAddrW) begin
                        state_d = StSub;
                    end else if (state_q == StSub) begin
                        state_d = StRstart;
                    end else begin
                        // The ID transaction reads a single byte.
                        state_d = txn_temp_q ? StRdHi : StRdLo;
                    end
                end
                StRdHi: begin
                    msb_d   = rsp_data;
                    state_d = StRdLo;
                end
                StRdLo: begin
                    lsb_d   = rsp_data;
                    state_d = StStop;
                end
                StStop: begin
                    nack_d = 1'b0;
                    if (nack_q) begin
                        retry_d = (retry_q == 2'd3) ? 2'd3 : retry_inc[1:0];
                        if (32'(retry_inc) > RETRY_MAX) begin
                            error_d = 1'b1;
                            state_d = StFail;
                        end else begin
                            state_d = enable ? StStart : StIdle;
                        end
                    end else if (txn_temp_q) begin
                        temp_d       = {msb_q, lsb_q};
                        temp_valid_d = 1'b1;
                        retry_d      = 2'd0;
                        if (enable) begin
                            state_d = StWait;
                            timer_d = TimerW'(POLL_CYCLES - 1);
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        id_d = lsb_q;
                        if (lsb_q == EXP_ID) begin
                            id_valid_d = 1'b1;
                            retry_d    = 2'd0;
                            txn_temp_d = 1'b1;
                            state_d    = enable ? StStart : StIdle;
                        end else begin
                            error_d = 1'b1;
                            state_d = StFail;
                        end
                    end
                end
                default: ;
            endcase
        end

        unique case (state_q)
            StIdle: begin
                if (enable && !error_q) begin
                    state_d    = StStart;
                    txn_temp_d = id_valid_q;
                end
            end
            StWait: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (timer_q == '0) begin
                    state_d    = StStart;
                    txn_temp_d = 1'b1;
                end else begin
                    timer_d = timer_q - TimerW'(1);
                end
            end
            StFail: begin
                // Leaving FAIL forces a fresh ID check on the next enable.
                if (!enable) begin
                    state_d    = StIdle;
                    error_d    = 1'b0;
                    id_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            pend_q       <= 1'b0;
            txn_temp_q   <= 1'b0;
            nack_q       <= 1'b0;
            retry_q      <= 2'd0;
            timer_q      <= '0;
            msb_q        <= 8'h00;
            lsb_q        <= 8'h00;
            id_q         <= 8'h00;
            id_valid_q   <= 1'b0;
            temp_q       <= 16'h0000;
            temp_valid_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            txn_temp_q   <= txn_temp_d;
            nack_q       <= nack_d;
            retry_q      <= retry_d;
            timer_q      <= timer_d;
            msb_q        <= msb_d;
            lsb_q        <= lsb_d;
            id_q         <= id_d;
            id_valid_q   <= id_valid_d;
            temp_q       <= temp_d;
            temp_valid_q <= temp_valid_d;
            error_q      <= error_d;
        end
    end

    assign id         = id_q;
    assign id_valid   = id_valid_q;
    assign temp       = temp_q;
    assign temp_valid = temp_valid_q;
    assign error      = error_q;

endmodule

// File: doc/i2c_poll_sequencer.md
Name: i2c_poll_sequencer

Overview:
- Transaction sequencer that drives a byte-level I2C master engine through a command/response handshake.
- After enable, it reads the device ID register once and checks it.
- It then reads the 16-bit temperature register every POLL_CYCLES clocks and publishes each result.
- It sits between the board-level display/readout logic and the I2C bit engine that owns scl/sda.

Parameters:
- DEV_ADDR, 7'h4B, 7-bit slave address.
- ID_REG, 8'hCB, ID register sub-address.
- EXP_ID, 8'hCB, expected ID value.
- TEMP_REG, 8'h00, temperature MSB sub-address (LSB auto-increments).
- POLL_CYCLES, 50000, clocks from the end of one temperature read's STOP to the next START (min 2).
- RETRY_MAX, 3, consecutive NACKed transactions tolerated before error.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- enable  in  1  run request; sampled every cycle.
- cmd_valid  out  1  command offered to engine.
- cmd_ready  in  1  engine accepts command.
- cmd_op  out  3  0=START, 1=WRITE, 2=READ_ACK, 3=READ_NACK, 4=STOP.
- cmd_data  out  8  byte for WRITE; 0 otherwise.
- rsp_valid  in  1  one-cycle pulse, completion of accepted command.
- rsp_data  in  8  read byte (READ_* only).
- rsp_nack  in  1  slave NACKed a WRITE; qualified by rsp_valid.
- id  out  8  last ID byte read.
- id_valid  out  1  high once ID read and matched.
- temp  out  16  {MSB,LSB} of last temperature read.
- temp_valid  out  1  one-cycle pulse when temp updates.
- busy  out  1  high from first START to final STOP response of a transaction.
- error  out  1  sticky fault flag.

Behaviour:
- Reset (async, reset=0): every output is 0, FSM=IDLE, retry count=0, poll timer=0, ID not yet read. cmd_valid drops immediately, with no handshake completion.
- Handshake:
  - A command transfers on a clk edge with cmd_valid&cmd_ready.
  - cmd_op/cmd_data are held stable while cmd_valid=1 and not ready.
  - cmd_valid deasserts the cycle after transfer.
  - Exactly one command is outstanding; the next cmd_valid rises no earlier than the cycle after rsp_valid.
  - rsp_valid while nothing is outstanding is ignored.
- States: IDLE, START, ADDR_W, SUB, RSTART, ADDR_R, RD_HI, RD_LO, STOP, WAIT, FAIL.
  - Each non-idle state has an ISSUE phase (cmd_valid=1) and a PEND phase (await rsp_valid).
  - The state advances on rsp_valid.
- ID transaction: START; WRITE {DEV_ADDR,0}; WRITE ID_REG; START; WRITE {DEV_ADDR,1}; READ_NACK; STOP.
- Temperature transaction: START; WRITE {DEV_ADDR,0}; WRITE TEMP_REG; START; WRITE {DEV_ADDR,1}; READ_ACK (MSB); READ_NACK (LSB); STOP.
- IDLE: when enable=1 and error=0, go to START. The ID transaction runs if ID is not yet read, otherwise the temperature transaction.
- RD_HI: latch rsp_data into the MSB holding register.
- RD_LO: latch the LSB.
- STOP response, temperature transaction:
  - temp <= {MSB,LSB}; temp_valid pulses that same cycle.
  - Retry count clears; go to WAIT with timer=POLL_CYCLES-1.
- STOP response, ID transaction:
  - If byte==EXP_ID: id<=byte, id_valid<=1, retry count clears, go straight to START (temperature read).
  - Else: id<=byte, error<=1, go to FAIL.
- WAIT: decrement the timer each cycle. At 0 go to START if enable=1, else IDLE.
- NACK (rsp_valid&rsp_nack on any WRITE):
  - Skip the remaining commands, issue STOP, then increment retry count.
  - If retry count now exceeds RETRY_MAX: error<=1, go to FAIL.
  - Otherwise restart the same transaction type after the STOP response; there is no poll wait.
- enable deasserted mid-transaction: the transaction completes normally through the STOP response (results still published), then IDLE. enable=0 in WAIT: go to IDLE immediately.
- FAIL: no commands are issued. Exit to IDLE only when enable=0; error and the ID-read flag are cleared on that exit so the next enable re-reads the ID.
- busy is 1 from the START ISSUE phase until the STOP response cycle inclusive.
- Retry count is 2 bits wide and saturates.

Test Plan:
- ID path: bench engine (ready=1, rsp 2 cycles after accept) returns ID 8'hCB, enable=1.
  - Command sequence is exactly START, WRITE 8'h96, WRITE 8'hCB, START, WRITE 8'h97, READ_NACK, STOP.
  - Then id=8'hCB, id_valid=1, error=0.
- Temperature read: engine returns MSB 8'h0C, LSB 8'h80 → temp=16'h0C80 with a single temp_valid pulse. With POLL_CYCLES=100, the next START is accepted 100 clocks after the STOP response.
- ID mismatch: engine returns 8'h00 for the ID → error=1, id=8'h00, no further cmd_valid.
  - Drop enable, then raise it → the ID transaction reruns.
- NACK retry: engine NACKs WRITE 8'h96 four times in a row → four STOP commands issued, then error=1 and FAIL.
  - With three NACKs then an ACK, the transaction succeeds and the retry count clears.
- Backpressure plus late enable drop: cmd_ready held 0 for 5 cycles on each command → cmd_op/cmd_data stay stable. Deasserting enable during RD_HI still completes the read, publishes temp, then IDLE with busy=0.
- Async reset: assert reset=0 mid-ADDR_R with cmd_valid=1 → all outputs 0 within the same cycle, before the next clk edge.
  - After release with enable=1, the ID transaction restarts from START.
